issue_queue_param: RTL and testbench
====================================

ISSUE_QUEUE_PARAM -- requirements
Module: issue_queue_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of queue entries, power of two, 4..64.
REQ-002 SHALL have parameter TAG_W, default 6: physical register tag width; tag 0 is the zero register.
REQ-003 SHALL have parameter DATA_W, default 32: operand width.
REQ-004 SHALL have parameter PAYLOAD_W, default 138: opaque control payload width, carried unmodified.
REQ-005 SHALL have parameter NUM_BC, default 2: number of result broadcast ports.
REQ-006 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-007 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port STALL, input, 1: freezes enqueue and issue.
REQ-009 SHALL have port FLUSH, input, 1: discards all entries.
REQ-010 SHALL have enqueue ports: enq_valid in 1; enq_ready out 1; enq_payload in PAYLOAD_W; enq_tag_a, enq_tag_b in TAG_W; enq_rdy_a, enq_rdy_b in 1; enq_val_a, enq_val_b in DATA_W.
REQ-011 SHALL have broadcast ports: bc_valid in NUM_BC; bc_tag in NUM_BC*TAG_W; bc_val in NUM_BC*DATA_W.
REQ-012 SHALL have issue ports: iss_valid out 1; iss_ready in 1; iss_payload out PAYLOAD_W; iss_op_a, iss_op_b out DATA_W.
REQ-013 SHALL have status outputs: count out $clog2(DEPTH+1); full out 1; empty out 1.

Function
REQ-014 SHALL accept an enqueue at a rising edge when enq_valid && enq_ready && !STALL && !FLUSH; enq_ready = !full.
REQ-015 SHALL treat source tag 0 as ready regardless of enq_rdy_x; the captured value is enq_val_x.
REQ-016 SHALL capture a broadcast whose tag matches an enqueuing not-ready source in the same cycle; the value is bc_val and the source is marked ready.
REQ-017 SHALL, every cycle including STALL cycles, update each valid entry's not-ready source on a matching bc_valid/bc_tag: value := bc_val, ready := 1; tag 0 never matches.
REQ-018 SHALL resolve multiple broadcast ports matching one source in favour of the lowest port index.
REQ-019 SHALL drive iss_valid combinationally high when !STALL and at least one valid entry has both sources ready.
REQ-020 SHALL select the oldest eligible entry, in enqueue order, using an age matrix; free-slot position SHALL NOT affect order.
REQ-021 SHALL remove the selected entry at the edge where iss_valid && iss_ready; iss_payload/iss_op_a/iss_op_b SHALL be stable while iss_valid && !iss_ready.
REQ-022 SHALL allow enqueue and issue at the same edge even when full; count is unchanged, and enq_ready still reflects the pre-edge full.
REQ-023 SHALL have minimum latency of 1: an entry enqueued ready at edge E asserts iss_valid in the cycle after E.
REQ-024 SHALL make an entry woken by a broadcast in cycle C issuable in cycle C+1, unless the configuration below applies.
REQ-025 SHALL, on FLUSH at an edge, clear all valid bits and age state; FLUSH overrides a same-edge enqueue and issue.
REQ-026 SHALL maintain count = number of valid entries, full = (count == DEPTH), and empty = (count == 0).

Reset
REQ-027 SHALL, while RESET is high at an edge, clear all valid, ready and age state and zero all stored operands and payloads.
REQ-028 SHALL output after reset: count=0, full=0, empty=1, enq_ready=1, iss_valid=0, iss_payload/iss_op_a/iss_op_b=0.
REQ-029 SHALL give RESET priority over FLUSH, STALL, enqueue and broadcast; reset mid-operation discards all in-flight entries.

Configuration
REQ-030 SHALL, with macro ISSUE_WAKEUP_BYPASS_EN defined, treat a source matching a same-cycle bc_valid/bc_tag as ready for selection.
REQ-031 SHALL, with ISSUE_WAKEUP_BYPASS_EN defined, forward the matching bc_val to iss_op_x in that cycle, giving 0-cycle wakeup-to-issue.
REQ-032 SHALL, without ISSUE_WAKEUP_BYPASS_EN, use only registered ready bits for selection, per REQ-024.

Verification (DEPTH=8, NUM_BC=2)
REQ-033 SHALL cover: enqueue 8 ready entries with payloads 1..8, iss_ready=0 -> full=1, enq_ready=0, count=8; then iss_ready=1 -> payloads issue as 1,2,...,8, one per cycle.
REQ-034 SHALL cover: enqueue A (tag_a=5, not ready) then ready B; issue blocked -> B issues first; then bc port1 tag 5, val 0xDEAD -> A issues next cycle with iss_op_a=0xDEAD (same cycle with bypass macro).
REQ-035 SHALL cover: both broadcast ports carry tag 7, values 0x11 and 0x22, against a waiting source -> captured value = 0x11.
REQ-036 SHALL cover: enqueue coinciding with a bc of its pending tag 9, val 0x55 -> entry issues with operand 0x55; no deadlock.
REQ-037 SHALL cover: 5 entries valid, FLUSH with simultaneous enqueue and issue -> count=0, empty=1, iss_valid=0 next cycle.
REQ-038 SHALL cover: full queue with enqueue and issue at the same edge -> count stays 8, the new entry is the youngest, STALL=1 -> iss_valid=0 and count is frozen.

Source files
------------

// File: rtl/issue_queue_param.sv
// Out-of-order issue queue: tag wakeup from NUM_BC broadcast ports, oldest-ready select via an age matrix.
// Optional macro ISSUE_WAKEUP_BYPASS_EN: a same-cycle broadcast counts as ready and its value is forwarded to issue.
module issue_queue_param #(
  parameter int DEPTH     = 16,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 138,
  parameter int NUM_BC    = 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       STALL,
  input  logic                       FLUSH,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [PAYLOAD_W-1:0]       enq_payload,
  input  logic [TAG_W-1:0]           enq_tag_a,
  input  logic [TAG_W-1:0]           enq_tag_b,
  input  logic                       enq_rdy_a,
  input  logic                       enq_rdy_b,
  input  logic [DATA_W-1:0]          enq_val_a,
  input  logic [DATA_W-1:0]          enq_val_b,
  input  logic [NUM_BC-1:0]          bc_valid,
  input  logic [NUM_BC*TAG_W-1:0]    bc_tag,
  input  logic [NUM_BC*DATA_W-1:0]   bc_val,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [PAYLOAD_W-1:0]       iss_payload,
  output logic [DATA_W-1:0]          iss_op_a,
  output logic [DATA_W-1:0]          iss_op_b,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] val;
  } bc_match_t;

  function automatic bc_match_t bc_match(input logic [TAG_W-1:0]        tag,
                                         input logic [NUM_BC-1:0]       v,
                                         input logic [NUM_BC*TAG_W-1:0] t,
                                         input logic [NUM_BC*DATA_W-1:0] d);
    bc_match_t m;
    m = '0;
    // Scan from the highest port down so the lowest matching port wins.
    for (int p = NUM_BC-1; p >= 0; p--) begin
      if (v[p] && tag != '0 && t[p*TAG_W +: TAG_W] == tag) begin
        m.hit = 1'b1;
        m.val = d[p*DATA_W +: DATA_W];
      end
    end
    return m;
  endfunction

  logic [DEPTH-1:0]     r_valid, r_rdy_a, r_rdy_b;
  logic [TAG_W-1:0]     r_tag_a   [DEPTH];
  logic [TAG_W-1:0]     r_tag_b   [DEPTH];
  logic [DATA_W-1:0]    r_val_a   [DEPTH];
  logic [DATA_W-1:0]    r_val_b   [DEPTH];
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic [DEPTH-1:0]     r_age     [DEPTH];  // r_age[i][j]: entry i was enqueued before entry j
  logic [CNT_W-1:0]     r_count;
  logic                 r_hold;
  logic [IDX_W-1:0]     r_hold_idx;

  bc_match_t         w_match_a [DEPTH];
  bc_match_t         w_match_b [DEPTH];
  bc_match_t         w_enq_match_a, w_enq_match_b;
  logic [DEPTH-1:0]  w_src_a, w_src_b, w_elig, w_is_oldest;
  logic [IDX_W-1:0]  w_oldest, w_free, w_sel, w_enq_slot;
  logic              w_iss_fire, w_enq_fire;
  logic              w_enq_rdy_a, w_enq_rdy_b;
  logic [DATA_W-1:0] w_enq_val_a, w_enq_val_b, w_op_a, w_op_b;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_match_a[i] = bc_match(r_tag_a[i], bc_valid, bc_tag, bc_val);
      w_match_b[i] = bc_match(r_tag_b[i], bc_valid, bc_tag, bc_val);
    end
    w_enq_match_a = bc_match(enq_tag_a, bc_valid, bc_tag, bc_val);
    w_enq_match_b = bc_match(enq_tag_b, bc_valid, bc_tag, bc_val);
  end

`ifdef ISSUE_WAKEUP_BYPASS_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_src_a[i] = r_rdy_a[i] | w_match_a[i].hit;
      w_src_b[i] = r_rdy_b[i] | w_match_b[i].hit;
    end
  end
`else
  assign w_src_a = r_rdy_a;
  assign w_src_b = r_rdy_b;
`endif

  // NOTE: every signal written here gets a default before the loops, so no latch can be inferred.
  always_comb begin
    w_elig   = r_valid & w_src_a & w_src_b;
    w_oldest = '0;
    w_free   = '0;
    for (int i = 0; i < DEPTH; i++)
      w_is_oldest[i] = w_elig[i] && ((r_age[i] | ~w_elig | (DEPTH'(1) << i)) == '1);
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (w_is_oldest[i]) w_oldest = IDX_W'(i);
      if (!r_valid[i])    w_free   = IDX_W'(i);
    end
  end

  // A presented-but-unaccepted entry stays selected even if an older one wakes up.
  assign w_sel      = r_hold ? r_hold_idx : w_oldest;
  assign iss_valid  = !STALL && (|w_elig);
  assign w_iss_fire = iss_valid && iss_ready;
  assign count      = r_count;
  assign full       = (r_count == CNT_W'(DEPTH));
  assign empty      = (r_count == '0);
  assign enq_ready  = !full;
  assign w_enq_fire = enq_valid && !STALL && !FLUSH && (!full || w_iss_fire);
  assign w_enq_slot = full ? w_sel : w_free;

  assign w_enq_rdy_a = (enq_tag_a == '0) || enq_rdy_a || w_enq_match_a.hit;
  assign w_enq_rdy_b = (enq_tag_b == '0) || enq_rdy_b || w_enq_match_b.hit;
  assign w_enq_val_a = ((enq_tag_a == '0) || enq_rdy_a) ? enq_val_a : w_enq_match_a.val;
  assign w_enq_val_b = ((enq_tag_b == '0) || enq_rdy_b) ? enq_val_b : w_enq_match_b.val;

`ifdef ISSUE_WAKEUP_BYPASS_EN
  assign w_op_a = r_rdy_a[w_sel] ? r_val_a[w_sel] : w_match_a[w_sel].val;
  assign w_op_b = r_rdy_b[w_sel] ? r_val_b[w_sel] : w_match_b[w_sel].val;
`else
  assign w_op_a = r_val_a[w_sel];
  assign w_op_b = r_val_b[w_sel];
`endif

  assign iss_payload = iss_valid ? r_payload[w_sel] : '0;
  assign iss_op_a    = iss_valid ? w_op_a : '0;
  assign iss_op_b    = iss_valid ? w_op_b : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid    <= '0;
      r_rdy_a    <= '0;
      r_rdy_b    <= '0;
      r_count    <= '0;
      r_hold     <= 1'b0;
      r_hold_idx <= '0;
      // NOTE: the entry storage is reset too, so stored operands and payloads read as zero afterwards.
      for (int i = 0; i < DEPTH; i++) begin
        r_age[i]     <= '0;
        r_tag_a[i]   <= '0;
        r_tag_b[i]   <= '0;
        r_val_a[i]   <= '0;
        r_val_b[i]   <= '0;
        r_payload[i] <= '0;
      end
    end else if (FLUSH) begin
      r_valid <= '0;
      r_count <= '0;
      r_hold  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && !r_rdy_a[i] && w_match_a[i].hit) begin
          r_rdy_a[i] <= 1'b1;
          r_val_a[i] <= w_match_a[i].val;
        end
        if (r_valid[i] && !r_rdy_b[i] && w_match_b[i].hit) begin
          r_rdy_b[i] <= 1'b1;
          r_val_b[i] <= w_match_b[i].val;
        end
      end
      if (w_iss_fire) r_valid[w_sel] <= 1'b0;
      if (w_enq_fire) begin
        r_valid[w_enq_slot]   <= 1'b1;
        r_payload[w_enq_slot] <= enq_payload;
        r_tag_a[w_enq_slot]   <= enq_tag_a;
        r_tag_b[w_enq_slot]   <= enq_tag_b;
        r_rdy_a[w_enq_slot]   <= w_enq_rdy_a;
        r_rdy_b[w_enq_slot]   <= w_enq_rdy_b;
        r_val_a[w_enq_slot]   <= w_enq_val_a;
        r_val_b[w_enq_slot]   <= w_enq_val_b;
        for (int j = 0; j < DEPTH; j++)
          r_age[j][w_enq_slot] <= (IDX_W'(j) != w_enq_slot);
        r_age[w_enq_slot] <= '0;
      end
      case ({w_enq_fire, w_iss_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_hold     <= iss_valid && !iss_ready;
      r_hold_idx <= w_sel;
    end
  end
endmodule

// File: tb/tb_issue_queue_param.sv
// Self-checking bench for issue_queue_param (DEPTH=8, NUM_BC=2): directed scenarios then random traffic,
// compared every cycle against an in-order list model of the queue.
module tb_issue_queue_param;
  localparam int DEPTH = 8;
  localparam int TW    = 6;
  localparam int DW    = 32;
  localparam int PW    = 138;
  localparam int NB    = 2;
  localparam int CW    = $clog2(DEPTH+1);

  typedef logic [PW-1:0] chk_t;

  logic           CLK = 1'b0;
  logic           RESET, STALL, FLUSH;
  logic           enq_valid, enq_ready;
  logic [PW-1:0]  enq_payload;
  logic [TW-1:0]  enq_tag_a, enq_tag_b;
  logic           enq_rdy_a, enq_rdy_b;
  logic [DW-1:0]  enq_val_a, enq_val_b;
  logic [NB-1:0]  bc_valid;
  logic [NB*TW-1:0] bc_tag;
  logic [NB*DW-1:0] bc_val;
  logic           iss_valid, iss_ready;
  logic [PW-1:0]  iss_payload;
  logic [DW-1:0]  iss_op_a, iss_op_b;
  logic [CW-1:0]  count;
  logic           full, empty;

  always #5 CLK = ~CLK;

  issue_queue_param #(.DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW), .PAYLOAD_W(PW), .NUM_BC(NB)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_payload(enq_payload),
    .enq_tag_a(enq_tag_a), .enq_tag_b(enq_tag_b), .enq_rdy_a(enq_rdy_a), .enq_rdy_b(enq_rdy_b),
    .enq_val_a(enq_val_a), .enq_val_b(enq_val_b),
    .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_val(bc_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
    .iss_op_a(iss_op_a), .iss_op_b(iss_op_b),
    .count(count), .full(full), .empty(empty)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input chk_t obs, input chk_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: entries kept in enqueue order, oldest at index 0.
  typedef struct {
    int            id;
    chk_t          pl;
    logic [TW-1:0] ta, tgb;
    logic          ra, rb;
    logic [DW-1:0] va, vb;
  } ent_t;

  ent_t q[$];
  int   held_id = -1;
  int   next_id = 0;

  function automatic bit bc_find(input logic [TW-1:0] t, output logic [DW-1:0] v);
    v = '0;
    if (t == '0) return 1'b0;
    for (int p = 0; p < NB; p++)
      if (bc_valid[p] && bc_tag[p*TW +: TW] == t) begin
        v = bc_val[p*DW +: DW];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic bit src_ok(input logic [TW-1:0] t, input logic r);
`ifdef ISSUE_WAKEUP_BYPASS_EN
    logic [DW-1:0] v;
    if (r) return 1'b1;
    return bc_find(t, v);
`else
    if (t == '1) return r;
    return r;
`endif
  endfunction

  function automatic logic [DW-1:0] op_of(input logic [TW-1:0] t, input logic r, input logic [DW-1:0] v);
    logic [DW-1:0] bv;
    if (r) return v;
    void'(bc_find(t, bv));
    return bv;
  endfunction

  function automatic int model_sel();
    if (held_id >= 0)
      foreach (q[i]) if (q[i].id == held_id) return i;
    foreach (q[i]) if (src_ok(q[i].ta, q[i].ra) && src_ok(q[i].tgb, q[i].rb)) return i;
    return -1;
  endfunction

  task automatic model_check();
    int   s;
    logic ev;
    s  = model_sel();
    ev = !STALL && (s >= 0);
    check("count",     chk_t'(count),     chk_t'(q.size()));
    check("full",      chk_t'(full),      chk_t'(q.size() == DEPTH));
    check("empty",     chk_t'(empty),     chk_t'(q.size() == 0));
    check("enq_ready", chk_t'(enq_ready), chk_t'(q.size() != DEPTH));
    check("iss_valid", chk_t'(iss_valid), chk_t'(ev));
    if (ev) begin
      check("iss_payload", iss_payload, q[s].pl);
      check("iss_op_a", chk_t'(iss_op_a), chk_t'(op_of(q[s].ta, q[s].ra, q[s].va)));
      check("iss_op_b", chk_t'(iss_op_b), chk_t'(op_of(q[s].tgb, q[s].rb, q[s].vb)));
    end
  endtask

  task automatic model_edge();
    int            s;
    logic          iv, fire_i, fire_e;
    logic [DW-1:0] bv;
    ent_t          e;
    if (RESET || FLUSH) begin
      q.delete();
      held_id = -1;
      return;
    end
    s      = model_sel();
    iv     = !STALL && (s >= 0);
    fire_i = iv && iss_ready;
    fire_e = enq_valid && !STALL && ((q.size() < DEPTH) || fire_i);
    foreach (q[i]) begin
      if (!q[i].ra && bc_find(q[i].ta, bv)) begin q[i].ra = 1'b1; q[i].va = bv; end
      if (!q[i].rb && bc_find(q[i].tgb, bv)) begin q[i].rb = 1'b1; q[i].vb = bv; end
    end
    held_id = (iv && !iss_ready) ? q[s].id : -1;
    if (fire_i) q.delete(s);
    if (fire_e) begin
      e.id = next_id;
      next_id++;
      e.pl  = enq_payload;
      e.ta  = enq_tag_a;
      e.tgb = enq_tag_b;
      if (enq_tag_a == '0 || enq_rdy_a)  begin e.ra = 1'b1; e.va = enq_val_a; end
      else if (bc_find(enq_tag_a, bv))   begin e.ra = 1'b1; e.va = bv;        end
      else                               begin e.ra = 1'b0; e.va = enq_val_a; end
      if (enq_tag_b == '0 || enq_rdy_b)  begin e.rb = 1'b1; e.vb = enq_val_b; end
      else if (bc_find(enq_tag_b, bv))   begin e.rb = 1'b1; e.vb = bv;        end
      else                               begin e.rb = 1'b0; e.vb = enq_val_b; end
      q.push_back(e);
    end
  endtask

  task automatic idle();
    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    enq_valid = 1'b0; enq_payload = '0;
    enq_tag_a = '0; enq_tag_b = '0; enq_rdy_a = 1'b0; enq_rdy_b = 1'b0;
    enq_val_a = '0; enq_val_b = '0;
    bc_valid = '0; bc_tag = '0; bc_val = '0;
    iss_ready = 1'b0;
  endtask

  task automatic set_enq(input chk_t pl, input logic [TW-1:0] ta, input logic ra, input logic [DW-1:0] va,
                         input logic [TW-1:0] tb, input logic rb, input logic [DW-1:0] vb);
    enq_valid = 1'b1; enq_payload = pl;
    enq_tag_a = ta; enq_rdy_a = ra; enq_val_a = va;
    enq_tag_b = tb; enq_rdy_b = rb; enq_val_b = vb;
  endtask

  task automatic set_bc(input int p, input logic [TW-1:0] t, input logic [DW-1:0] v);
    bc_valid[p]         = 1'b1;
    bc_tag[p*TW +: TW]  = t;
    bc_val[p*DW +: DW]  = v;
  endtask

  task automatic sample();
    #2;
    model_check();
  endtask

  task automatic edge_();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic tick();
    sample();
    edge_();
  endtask

  initial begin
    logic [159:0] rnd;
    int           r;

    idle();
    RESET = 1'b1;
    edge_();
    edge_();

    // Reset state
    idle();
    sample();
    check("rst_count",     chk_t'(count),     chk_t'(0));
    check("rst_full",      chk_t'(full),      chk_t'(0));
    check("rst_empty",     chk_t'(empty),     chk_t'(1));
    check("rst_enq_ready", chk_t'(enq_ready), chk_t'(1));
    check("rst_iss_valid", chk_t'(iss_valid), chk_t'(0));
    check("rst_payload",   iss_payload,       chk_t'(0));
    check("rst_op_a",      chk_t'(iss_op_a),  chk_t'(0));
    check("rst_op_b",      chk_t'(iss_op_b),  chk_t'(0));
    edge_();

    // Fill with 8 ready entries, then drain in enqueue order
    for (int k = 1; k <= 8; k++) begin
      idle();
      set_enq(chk_t'(k), 6'd0, 1'b1, 32'(k * 3), 6'd0, 1'b1, 32'(k * 5));
      tick();
    end
    idle();
    sample();
    check("fill_full",      chk_t'(full),      chk_t'(1));
    check("fill_enq_ready", chk_t'(enq_ready), chk_t'(0));
    check("fill_count",     chk_t'(count),     chk_t'(8));
    edge_();
    for (int k = 1; k <= 8; k++) begin
      idle();
      iss_ready = 1'b1;
      sample();
      check("drain_order", iss_payload, chk_t'(k));
      edge_();
    end

    // Waiting source A is overtaken by ready B, then woken by port 1
    idle();
    set_enq(chk_t'(32'hA), 6'd5, 1'b0, 32'h0, 6'd0, 1'b1, 32'h1234);
    tick();
    idle();
    set_enq(chk_t'(32'hB), 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2);
    tick();
    idle();
    iss_ready = 1'b1;
    sample();
    check("lat1_iss_valid", chk_t'(iss_valid), chk_t'(1));
    check("b_first",        iss_payload,       chk_t'(32'hB));
    edge_();
    idle();
    iss_ready = 1'b1;
    set_bc(1, 6'd5, 32'hDEAD);
    sample();
`ifdef ISSUE_WAKEUP_BYPASS_EN
    check("bypass_valid", chk_t'(iss_valid), chk_t'(1));
    check("bypass_pl",    iss_payload,       chk_t'(32'hA));
    check("bypass_op_a",  chk_t'(iss_op_a),  chk_t'(32'hDEAD));
    edge_();
`else
    check("wake_same_cycle_idle", chk_t'(iss_valid), chk_t'(0));
    edge_();
    idle();
    iss_ready = 1'b1;
    sample();
    check("wake_valid", chk_t'(iss_valid), chk_t'(1));
    check("wake_pl",    iss_payload,       chk_t'(32'hA));
    check("wake_op_a",  chk_t'(iss_op_a),  chk_t'(32'hDEAD));
    check("wake_op_b",  chk_t'(iss_op_b),  chk_t'(32'h1234));
    edge_();
`endif

    // Both ports carry the same tag: port 0 wins
    idle();
    set_enq(chk_t'(32'hC), 6'd7, 1'b0, 32'h0, 6'd0, 1'b1, 32'h3);
    tick();
    idle();
    set_bc(0, 6'd7, 32'h11);
    set_bc(1, 6'd7, 32'h22);
    tick();
    idle();
    iss_ready = 1'b1;
    sample();
    check("dual_bc_valid", chk_t'(iss_valid), chk_t'(1));
    check("dual_bc_op_a",  chk_t'(iss_op_a),  chk_t'(32'h11));
    edge_();

    // Broadcast coincides with enqueue of its pending tag
    idle();
    set_enq(chk_t'(32'hD), 6'd0, 1'b1, 32'h7, 6'd9, 1'b0, 32'h0);
    set_bc(0, 6'd9, 32'h55);
    tick();
    idle();
    iss_ready = 1'b1;
    sample();
    check("enq_bc_valid", chk_t'(iss_valid), chk_t'(1));
    check("enq_bc_pl",    iss_payload,       chk_t'(32'hD));
    check("enq_bc_op_b",  chk_t'(iss_op_b),  chk_t'(32'h55));
    edge_();

    // FLUSH overrides same-edge enqueue and issue
    for (int k = 0; k < 5; k++) begin
      idle();
      set_enq(chk_t'(32'h40 + k), 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0);
      tick();
    end
    idle();
    FLUSH = 1'b1;
    iss_ready = 1'b1;
    set_enq(chk_t'(32'h50), 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0);
    sample();
    check("pre_flush_count", chk_t'(count), chk_t'(5));
    edge_();
    idle();
    sample();
    check("flush_count",     chk_t'(count),     chk_t'(0));
    check("flush_empty",     chk_t'(empty),     chk_t'(1));
    check("flush_iss_valid", chk_t'(iss_valid), chk_t'(0));
    edge_();

    // Full queue: enqueue and issue together, then STALL freezes
    for (int k = 0; k < 8; k++) begin
      idle();
      set_enq(chk_t'(32'h21 + k), 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0);
      tick();
    end
    idle();
    set_enq(chk_t'(32'h29), 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0);
    iss_ready = 1'b1;
    sample();
    check("swap_enq_ready", chk_t'(enq_ready), chk_t'(0));
    check("swap_issue_pl",  iss_payload,       chk_t'(32'h21));
    edge_();
    idle();
    sample();
    check("swap_count", chk_t'(count), chk_t'(8));
    edge_();
    idle();
    STALL = 1'b1;
    iss_ready = 1'b1;
    set_enq(chk_t'(32'h30), 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) begin
      sample();
      check("stall_iss_valid", chk_t'(iss_valid), chk_t'(0));
      check("stall_count",     chk_t'(count),     chk_t'(8));
      edge_();
    end
    for (int k = 0; k < 8; k++) begin
      idle();
      iss_ready = 1'b1;
      sample();
      check("swap_drain_order", iss_payload, chk_t'(32'h22 + k));
      edge_();
    end

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      r     = int'($urandom_range(0, 999));
      RESET = (r < 5);
      FLUSH = (r >= 5) && (r < 25);
      STALL = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) != 0) begin
        rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        set_enq(rnd[PW-1:0],
                TW'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), $urandom(),
                TW'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), $urandom());
      end
      for (int p = 0; p < NB; p++)
        if ($urandom_range(0, 2) == 0) set_bc(p, TW'($urandom_range(0, 12)), $urandom());
      iss_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
